// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
//   dm_state_t : responder FSM states
//   BWEB_NONE  : active-low byte-enable value that writes no bytes
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } dm_state_t;

    localparam logic [3:0] BWEB_NONE = 4'hF;

endpackage

// File: rtl/dm_addr_decode.sv
// Address decode for the DM window.
//   addr_i   : CPU byte address
//   hit_o    : address falls inside the DM window starting at BASE_ADDR
//   sram_a_o : SRAM word address (byte address with the byte offset dropped)
module dm_addr_decode #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic [31:0]       addr_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] sram_a_o
);

    assign hit_o    = (addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign sram_a_o = addr_i[ADDR_W+1:2];

    // Byte offset is irrelevant for word accesses.
    logic unused_byte_ofs;
    assign unused_byte_ofs = ^addr_i[1:0];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: turns MEM-stage load/store requests into single SRAM
// cycles and hides multi-cycle latency behind DM_stall.
//   clk, rst             : clock, asynchronous active-low reset
//   DM_WEB / DM_write    : load / store request strobes (store wins if both set)
//   DM_BWEB, DM_addr,
//   DM_DI                : byte enables (active-low), byte address, store data
//   cpu_hold             : CPU frozen elsewhere; keeps the responder parked in DONE
//   DM_DO, DM_stall      : load data, MEM-stage hold
//   bus_err              : one-cycle pulse for an address outside the window
//   sram_*               : registered SRAM strobes/address/data, sram_DO read data
//
// Handshake: a request is the level DM_WEB|DM_write, held stable by the CPU
// while DM_stall=1. The access is complete in the cycle DM_stall drops (DONE);
// load data is valid on DM_DO in that cycle and stays there until the next load.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter int          SRAM_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_WEB,
    input  logic              DM_write,
    input  logic [3:0]        DM_BWEB,
    input  logic [31:0]       DM_addr,
    input  logic [31:0]       DM_DI,
    input  logic              cpu_hold,
    output logic [31:0]       DM_DO,
    output logic              DM_stall,
    output logic              bus_err,
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [3:0]        sram_BWEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [31:0]       sram_DI,
    input  logic [31:0]       sram_DO
);

    localparam logic [2:0] LAT_INIT = 3'(SRAM_LAT - 1);

    dm_state_t         state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              ceb_q, ceb_d;
    logic              web_q, web_d;
    logic [3:0]        bweb_q, bweb_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       di_q, di_d;

    logic              req;
    logic              hit;
    logic [ADDR_W-1:0] dec_a;

    assign req = DM_WEB | DM_write;

    dm_addr_decode #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_decode (
        .addr_i  (DM_addr),
        .hit_o   (hit),
        .sram_a_o(dec_a)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= 3'd0;
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
            ceb_q     <= 1'b1;
            web_q     <= 1'b1;
            bweb_q    <= BWEB_NONE;
            a_q       <= '0;
            di_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            ceb_q     <= ceb_d;
            web_q     <= web_d;
            bweb_q    <= bweb_d;
            a_q       <= a_d;
            di_q      <= di_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        ceb_d     = ceb_q;
        web_d     = web_q;
        bweb_d    = bweb_q;
        a_d       = a_q;
        di_d      = di_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // Strobes are loaded now so the SRAM sees them during ISSUE.
                        state_d = ISSUE;
                        ceb_d   = 1'b0;
                        web_d   = ~DM_write;
                        bweb_d  = DM_BWEB;
                        a_d     = dec_a;
                        di_d    = DM_DI;
                    end else begin
                        state_d   = DONE;
                        rdata_d   = 32'd0;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // The SRAM samples at the end of this cycle; drop the strobes.
                ceb_d = 1'b1;
                web_d = 1'b1;
                if (!web_q) begin
                    state_d = DONE;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    rdata_d = sram_DO;
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (!cpu_hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by rst so the MEM stage is released as soon as reset asserts,
    // even while the CPU still presents the abandoned request.
    assign DM_stall = rst & (((state_q == IDLE) & req) |
                             (state_q == ISSUE) |
                             (state_q == WAIT));

    assign DM_DO     = rdata_q;
    assign bus_err   = bus_err_q;
    assign sram_CEB  = ceb_q;
    assign sram_WEB  = web_q;
    assign sram_BWEB = bweb_q;
    assign sram_A    = a_q;
    assign sram_DI   = di_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with SRAM_LAT=1 (with a
// read/write SRAM model) and one with SRAM_LAT=3 (read-only pipelined model).
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        web1, wr1, web3, wr3;
    logic [3:0]  dm_bweb;
    logic [31:0] dm_addr;
    logic [31:0] dm_di;
    logic        cpu_hold;

    logic [31:0] s1_dm_do, s3_dm_do;
    logic        s1_stall, s3_stall;
    logic        s1_err, s3_err;
    logic        s1_ceb, s3_ceb;
    logic        s1_web, s3_web;
    logic [3:0]  s1_bweb, s3_bweb;
    logic [13:0] s1_a, s3_a;
    logic [31:0] s1_di, s3_di;
    logic [31:0] s1_do, s3_do;

    int errors = 0;
    int checks = 0;
    int ceb1 = 0;
    int ceb3 = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    dm_responder #(.ADDR_W(14), .SRAM_LAT(1), .BASE_ADDR(32'h0001_0000)) u1 (
        .clk(clk), .rst(rst), .DM_WEB(web1), .DM_write(wr1), .DM_BWEB(dm_bweb),
        .DM_addr(dm_addr), .DM_DI(dm_di), .cpu_hold(cpu_hold),
        .DM_DO(s1_dm_do), .DM_stall(s1_stall), .bus_err(s1_err),
        .sram_CEB(s1_ceb), .sram_WEB(s1_web), .sram_BWEB(s1_bweb),
        .sram_A(s1_a), .sram_DI(s1_di), .sram_DO(s1_do)
    );

    dm_responder #(.ADDR_W(14), .SRAM_LAT(3), .BASE_ADDR(32'h0001_0000)) u3 (
        .clk(clk), .rst(rst), .DM_WEB(web3), .DM_write(wr3), .DM_BWEB(dm_bweb),
        .DM_addr(dm_addr), .DM_DI(dm_di), .cpu_hold(cpu_hold),
        .DM_DO(s3_dm_do), .DM_stall(s3_stall), .bus_err(s3_err),
        .sram_CEB(s3_ceb), .sram_WEB(s3_web), .sram_BWEB(s3_bweb),
        .sram_A(s3_a), .sram_DI(s3_di), .sram_DO(s3_do)
    );

    // ---------------- SRAM models ----------------
    logic [31:0] mem1 [0:16383];
    logic [31:0] mem3 [0:16383];
    logic [31:0] rd1;
    logic [31:0] d0, d1, d2;

    initial begin
        mem1[2]     <= 32'hAAAA_AAAA;
        mem1[3]     <= 32'h0000_0000;
        mem1[4]     <= 32'hDEAD_BEEF;
        mem1[9]     <= 32'h0BAD_F00D;
        mem1[16383] <= 32'hCAFE_F00D;
        mem3[5]     <= 32'h0F0F_0F0F;
        mem3[6]     <= 32'h1234_5678;
        mem3[7]     <= 32'h9ABC_DEF0;
    end

    always @(posedge clk) begin
        if (!s1_ceb) begin
            if (!s1_web) begin
                for (int b = 0; b < 4; b++)
                    if (!s1_bweb[b]) mem1[s1_a][8*b +: 8] <= s1_di[8*b +: 8];
            end else begin
                rd1 <= mem1[s1_a];
            end
        end
    end
    assign s1_do = rd1;

    always @(posedge clk) begin
        if (!s3_ceb && s3_web) d0 <= mem3[s3_a];
        d1 <= d0;
        d2 <= d1;
    end
    assign s3_do = d2;

    // Count SRAM cycles seen by each model.
    always @(posedge clk) begin
        if (!s1_ceb) ceb1++;
        if (!s3_ceb) ceb3++;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request in IDLE, counts stall cycles, returns in the DONE cycle.
    task automatic access(input int which, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] di,
                          input logic [3:0] bweb, output int stalls,
                          output logic [31:0] data, output logic err);
        @(posedge clk); #1;
        dm_addr = addr;
        dm_di   = di;
        dm_bweb = bweb;
        if (which == 1) begin web1 = rd; wr1 = wr; end
        else            begin web3 = rd; wr3 = wr; end
        #1;
        stalls = 0;
        while (((which == 1) ? s1_stall : s3_stall) && stalls < 20) begin
            stalls++;
            @(posedge clk); #2;
        end
        data = (which == 1) ? s1_dm_do : s3_dm_do;
        err  = (which == 1) ? s1_err : s3_err;
        web1 = 1'b0; wr1 = 1'b0; web3 = 1'b0; wr3 = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int          st;
    logic [31:0] rd;
    logic        er;
    int          snap;

    initial begin
        rst = 1'b0;
        web1 = 1'b0; wr1 = 1'b0; web3 = 1'b0; wr3 = 1'b0;
        dm_bweb = 4'hF; dm_addr = 32'd0; dm_di = 32'd0; cpu_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(s1_stall), 32'd0);
        check("rst_ceb",   32'(s1_ceb),   32'd1);
        check("rst_web",   32'(s1_web),   32'd1);
        check("rst_bweb",  32'(s1_bweb),  32'hF);
        check("rst_a",     32'(s1_a),     32'd0);
        check("rst_di",    s1_di,         32'd0);
        check("rst_do",    s1_dm_do,      32'd0);
        check("rst_err",   32'(s1_err),   32'd0);
        check("rst_ceb3",  32'(s3_ceb),   32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: basic load
        access(1, 1'b1, 1'b0, 32'h0001_0010, 32'd0, 4'hF, st, rd, er);
        check("t1_stalls", 32'(st), 32'd3);
        check("t1_data",   rd,      32'hDEAD_BEEF);
        check("t1_err",    32'(er), 32'd0);

        // 2: partial store then load
        snap = ceb1;
        access(1, 1'b0, 1'b1, 32'h0001_0008, 32'h1122_3344, 4'b1100, st, rd, er);
        check("t2_st_stalls", 32'(st), 32'd2);
        check("t2_st_do_kept", rd, 32'hDEAD_BEEF);
        check("t2_st_sram_cycles", 32'(ceb1 - snap), 32'd1);
        access(1, 1'b1, 1'b0, 32'h0001_0008, 32'd0, 4'hF, st, rd, er);
        check("t2_ld_stalls", 32'(st), 32'd3);
        check("t2_ld_data",   rd,      32'hAAAA_3344);

        // both strobes set: treated as a full store
        access(1, 1'b1, 1'b1, 32'h0001_000C, 32'h5566_7788, 4'h0, st, rd, er);
        check("t2b_both_stalls", 32'(st), 32'd2);
        access(1, 1'b1, 1'b0, 32'h0001_000C, 32'd0, 4'hF, st, rd, er);
        check("t2b_data", rd, 32'h5566_7788);

        // store with no bytes enabled still costs one SRAM cycle
        snap = ceb1;
        access(1, 1'b0, 1'b1, 32'h0001_0024, 32'hFFFF_FFFF, 4'hF, st, rd, er);
        check("t2c_stalls", 32'(st), 32'd2);
        check("t2c_sram_cycles", 32'(ceb1 - snap), 32'd1);
        access(1, 1'b1, 1'b0, 32'h0001_0024, 32'd0, 4'hF, st, rd, er);
        check("t2c_data", rd, 32'h0BAD_F00D);

        // window edges
        access(1, 1'b1, 1'b0, 32'h0001_FFFC, 32'd0, 4'hF, st, rd, er);
        check("edge_top_data", rd, 32'hCAFE_F00D);
        check("edge_top_err",  32'(er), 32'd0);
        access(1, 1'b1, 1'b0, 32'h0002_0000, 32'd0, 4'hF, st, rd, er);
        check("edge_past_err",  32'(er), 32'd1);
        check("edge_past_data", rd, 32'd0);

        // 3: out-of-window load
        access(1, 1'b1, 1'b0, 32'h0001_0010, 32'd0, 4'hF, st, rd, er);
        snap = ceb1;
        access(1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'hF, st, rd, er);
        check("t3_stalls", 32'(st), 32'd1);
        check("t3_err",    32'(er), 32'd1);
        check("t3_data",   rd,      32'd0);
        check("t3_no_sram", 32'(ceb1 - snap), 32'd0);
        @(posedge clk); #2;
        check("t3_err_pulse", 32'(s1_err), 32'd0);

        // 4: hold in DONE
        cpu_hold = 1'b1;
        access(1, 1'b1, 1'b0, 32'h0001_0010, 32'd0, 4'hF, st, rd, er);
        check("t4_data", rd, 32'hDEAD_BEEF);
        snap = ceb1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            check("t4_hold_do",    s1_dm_do,       32'hDEAD_BEEF);
            check("t4_hold_stall", 32'(s1_stall),  32'd0);
        end
        // a new request during hold must not start
        web1 = 1'b1; dm_addr = 32'h0001_0008;
        @(posedge clk); #2;
        check("t4_req_in_hold_stall", 32'(s1_stall), 32'd0);
        check("t4_no_sram", 32'(ceb1 - snap), 32'd0);
        web1 = 1'b0;
        cpu_hold = 1'b0;
        access(1, 1'b1, 1'b0, 32'h0001_0008, 32'd0, 4'hF, st, rd, er);
        check("t4_after_stalls", 32'(st), 32'd3);
        check("t4_after_data",   rd,      32'hAAAA_3344);
        check("t4_after_sram",   32'(ceb1 - snap), 32'd1);

        // 6: SRAM_LAT=3 back-to-back loads
        access(3, 1'b1, 1'b0, 32'h0001_0018, 32'd0, 4'hF, st, rd, er);
        check("t6_a_stalls", 32'(st), 32'd5);
        check("t6_a_data",   rd,      32'h1234_5678);
        access(3, 1'b1, 1'b0, 32'h0001_001C, 32'd0, 4'hF, st, rd, er);
        check("t6_b_stalls", 32'(st), 32'd5);
        check("t6_b_data",   rd,      32'h9ABC_DEF0);

        // 5: reset during WAIT
        @(posedge clk); #1;
        web3 = 1'b1; dm_addr = 32'h0001_0014;
        @(posedge clk); #2;
        check("t5_issue_ceb", 32'(s3_ceb), 32'd0);
        @(posedge clk); #1;
        check("t5_wait_stall", 32'(s3_stall), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_stall", 32'(s3_stall), 32'd0);
        check("t5_rst_ceb",   32'(s3_ceb),   32'd1);
        check("t5_rst_do",    s3_dm_do,      32'd0);
        web3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        access(3, 1'b1, 1'b0, 32'h0001_0014, 32'd0, 4'hF, st, rd, er);
        check("t5_after_stalls", 32'(st), 32'd5);
        check("t5_after_data",   rd,      32'h0F0F_0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
